tlul_sram_dev: RTL and testbench

TL-UL device-side single-port SRAM that terminates the instruction or data host port of `ibex_tlul`. It consumes `tl_h2d_t` requests, performs reads and byte-masked writes on an internal word array, and returns in-order `tl_d2h_t` responses through a 2-entry response buffer. After reset it clears the memory with a dedicated init state machine. Each Ibex port (`tl_i_o`, `tl_d_o`) gets one instance.

---
 rtl/tlul_sram_dev.sv | 241 ++++++++++++++++++++++++
 tb/tb_tlul_sram_dev.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_sram_dev.sv
// TL-UL device-side single-port SRAM with a power-on clear sequence and a
// 2-entry in-order response buffer. Holds the TL-UL types and the response
// integrity generator it depends on so the file stands alone.

package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [31:0] d_data;
        tl_d_user_t  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// Fills d_user with folded-parity check bits over the response header and data.
module tlul_rsp_intg_gen (
    input  tlul_pkg::tl_d2h_t tl_i,
    output tlul_pkg::tl_d2h_t tl_o
);
    logic [13:0] rsp_bits;
    logic [6:0]  rsp_p;
    logic [6:0]  data_p;

    assign rsp_bits = {tl_i.d_opcode, tl_i.d_size, tl_i.d_source, tl_i.d_error};

    always_comb begin
        rsp_p  = '0;
        data_p = '0;
        for (int i = 0; i < 14; i++) begin
            rsp_p[i % 7] = rsp_p[i % 7] ^ rsp_bits[i];
        end
        for (int i = 0; i < 32; i++) begin
            data_p[i % 7] = data_p[i % 7] ^ tl_i.d_data[i];
        end
        tl_o                  = tl_i;
        tl_o.d_user.rsp_intg  = rsp_p;
        tl_o.d_user.data_intg = data_p;
    end
endmodule

module tlul_sram_dev #(
    parameter int unsigned MemWords = 1024,
    parameter logic [31:0] BaseAddr = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  tlul_pkg::tl_h2d_t tl_i,
    output tlul_pkg::tl_d2h_t tl_o,
    output logic              init_done_o
);
    import tlul_pkg::*;

    localparam int unsigned AW = $clog2(MemWords);

    typedef enum logic {StInit, StRun} state_e;

    typedef struct packed {
        tl_d_op_e    opcode;
        logic [1:0]  size;
        logic [7:0]  source;
        logic [31:0] data;
        logic        error;
    } rsp_t;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    rsp_t          buf_q [2];
    rsp_t          buf_d [2];
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    count_q, count_d;
    logic [31:0]   mem_q [MemWords];

    logic          a_ready, a_fire, d_fire;
    logic          hit, is_get, is_put, req_err;
    logic [AW-1:0] idx;
    logic [3:0]    wr_be;
    rsp_t          new_rsp;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    tl_d2h_t       rsp_raw;
    logic          unused_tl;

    // Handshake: a beat moves on A when a_valid && a_ready and on D when
    // d_valid && d_ready; the buffer never bypasses a full slot in one cycle.
    assign a_ready = (state_q == StRun) && (count_q < 2'd2);
    assign a_fire  = tl_i.a_valid && a_ready;
    assign d_fire  = (count_q != 2'd0) && tl_i.d_ready;

    assign hit     = (tl_i.a_address[31:AW+2] == BaseAddr[31:AW+2]);
    assign idx     = tl_i.a_address[AW+1:2];
    assign is_get  = (tl_i.a_opcode == Get);
    assign is_put  = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    assign req_err = !hit || (tl_i.a_size == 2'd3) || !(is_get || is_put) ||
                     ((tl_i.a_opcode == PutFullData) && (tl_i.a_mask != 4'hF));
    assign wr_be   = (tl_i.a_opcode == PutPartialData) ? tl_i.a_mask : 4'hF;

    always_comb begin
        new_rsp        = '0;
        new_rsp.opcode = is_get ? AccessAckData : AccessAck;
        new_rsp.size   = tl_i.a_size;
        new_rsp.source = tl_i.a_source;
        new_rsp.data   = (is_get && !req_err) ? mem_q[idx] : '0;
        new_rsp.error  = req_err;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == StInit) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(MemWords - 1)) begin
                state_d = StRun;
            end
        end
    end

    // The init sweep owns the write port until RUN; afterwards only
    // error-free Puts write.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = idx;
        mem_wdata = tl_i.a_data;
        mem_be    = wr_be;
        if (state_q == StInit) begin
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_wdata = '0;
            mem_be    = 4'hF;
        end else if (a_fire && is_put && !req_err) begin
            mem_we = 1'b1;
        end
    end

    always_comb begin
        buf_d    = buf_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (a_fire) begin
            buf_d[wr_ptr_q] = new_rsp;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (d_fire) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, a_fire} - {1'b0, d_fire};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StInit;
            cnt_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            buf_q    <= buf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rsp_raw          = '0;
        rsp_raw.d_valid  = (count_q != 2'd0);
        rsp_raw.d_opcode = buf_q[rd_ptr_q].opcode;
        rsp_raw.d_size   = buf_q[rd_ptr_q].size;
        rsp_raw.d_source = buf_q[rd_ptr_q].source;
        rsp_raw.d_data   = buf_q[rd_ptr_q].data;
        rsp_raw.d_error  = buf_q[rd_ptr_q].error;
        rsp_raw.a_ready  = a_ready;
    end

    tlul_rsp_intg_gen u_rsp_intg (
        .tl_i (rsp_raw),
        .tl_o (tl_o)
    );

    assign init_done_o = (state_q == StRun);
    assign unused_tl   = ^{tl_i.a_param, tl_i.a_user, tl_i.a_address[1:0]};

endmodule

// File: tb/tb_tlul_sram_dev.sv
// Bench for tlul_sram_dev: directed literal checks plus randomized traffic
// compared every cycle against a queue/array model of the device.
module tb_tlul_sram_dev;
    import tlul_pkg::*;

    localparam int          MW   = 16;
    localparam logic [31:0] BASE = 32'h0;

    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [7:0]  src;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    tl_h2d_t h2d;
    tl_d2h_t d2h;
    logic    init_done;

    int checks = 0;
    int errors = 0;

    rsp_t        exp_q[$];
    logic [31:0] mem_m [MW];
    int          init_cnt = 0;
    bit          run = 1'b0;
    bit          m_acc = 1'b0;

    always #5 clk = ~clk;

    tlul_sram_dev #(.MemWords(MW), .BaseAddr(BASE)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .tl_i        (h2d),
        .tl_o        (d2h),
        .init_done_o (init_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // What the device must answer for the request on the bus, updating the
    // memory image when the request is a legal write.
    function automatic rsp_t apply_req();
        rsp_t        r;
        logic [31:0] a;
        logic [2:0]  op;
        int          idx;
        bit          hit;
        bit          err;
        a   = h2d.a_address;
        op  = h2d.a_opcode;
        hit = (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + MW * 4);
        idx = hit ? int'((a - BASE) >> 2) : 0;
        err = !hit || (h2d.a_size > 2'd2) || !(op inside {3'h0, 3'h1, 3'h4}) ||
              (op == 3'h0 && h2d.a_mask != 4'hF);
        r.op   = (op == 3'h4) ? 3'h1 : 3'h0;
        r.size = h2d.a_size;
        r.src  = h2d.a_source;
        r.err  = err;
        r.data = (op == 3'h4 && !err) ? mem_m[idx] : 32'h0;
        if (!err && op != 3'h4) begin
            for (int b = 0; b < 4; b++) begin
                if (op == 3'h0 || h2d.a_mask[b]) mem_m[idx][8*b +: 8] = h2d.a_data[8*b +: 8];
            end
        end
        return r;
    endfunction

    initial begin
        bit acc;
        bit pop;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                run      = 1'b0;
                init_cnt = 0;
                m_acc    = 1'b0;
                foreach (mem_m[i]) mem_m[i] = 32'h0;
            end else if (!run) begin
                m_acc = 1'b0;
                init_cnt++;
                if (init_cnt == MW) run = 1'b1;
            end else begin
                acc = h2d.a_valid && (exp_q.size() < 2);
                pop = (exp_q.size() != 0) && h2d.d_ready;
                if (pop) void'(exp_q.pop_front());
                if (acc) exp_q.push_back(apply_req());
                m_acc = acc;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("init_done", init_done, run);
            chk("a_ready", d2h.a_ready, run && (exp_q.size() < 2));
            chk("d_valid", d2h.d_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("d_opcode", d2h.d_opcode, exp_q[0].op);
                chk("d_size", d2h.d_size, exp_q[0].size);
                chk("d_source", d2h.d_source, exp_q[0].src);
                chk("d_data", d2h.d_data, exp_q[0].data);
                chk("d_error", d2h.d_error, exp_q[0].err);
                chk("d_param", d2h.d_param, 3'h0);
                chk("d_sink", d2h.d_sink, 1'b0);
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input logic [1:0] size, input logic [7:0] src);
        h2d.a_valid   = 1'b1;
        h2d.a_opcode  = tl_a_op_e'(op);
        h2d.a_address = addr;
        h2d.a_data    = data;
        h2d.a_mask    = mask;
        h2d.a_size    = size;
        h2d.a_source  = src;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [7:0] src);
        bit done = 1'b0;
        drive(op, addr, data, mask, 2'd2, src);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_acc) begin
                done = 1'b1;
                break;
            end
        end
        chk("accept_wait", done, 1'b1);
        h2d.a_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string nm, input logic [2:0] op, input logic [31:0] data,
                              input logic err);
        for (int i = 0; i < 50 && !d2h.d_valid; i++) @(negedge clk);
        chk({nm, "_valid"}, d2h.d_valid, 1'b1);
        chk({nm, "_op"}, d2h.d_opcode, op);
        chk({nm, "_data"}, d2h.d_data, data);
        chk({nm, "_err"}, d2h.d_error, err);
        @(negedge clk);
    endtask

    task automatic wait_init(input string nm);
        int n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (init_done) break;
        end
        chk(nm, n, MW);
        chk({nm, "_a_ready"}, d2h.a_ready, 1'b1);
    endtask

    initial begin
        int r;
        h2d         = '0;
        h2d.d_ready = 1'b1;

        @(negedge clk);
        chk("rst_a_ready", d2h.a_ready, 1'b0);
        chk("rst_d_valid", d2h.d_valid, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_init("init_len");

        send(3'h4, 32'h0, 32'h0, 4'hF, 8'h01);
        chk("get0_latency", d2h.d_valid, 1'b1);
        expect_rsp("get0", 3'h1, 32'h0, 1'b0);

        send(3'h0, 32'h8, 32'hDEADBEEF, 4'hF, 8'h02);
        expect_rsp("putfull", 3'h0, 32'h0, 1'b0);
        send(3'h4, 32'h8, 32'h0, 4'hF, 8'h03);
        expect_rsp("get8a", 3'h1, 32'hDEADBEEF, 1'b0);

        send(3'h1, 32'h8, 32'h0000_5500, 4'b0010, 8'h04);
        expect_rsp("putpart", 3'h0, 32'h0, 1'b0);
        send(3'h4, 32'h8, 32'h0, 4'hF, 8'h05);
        expect_rsp("get8b", 3'h1, 32'hDEAD55EF, 1'b0);

        send(3'h4, 32'h40, 32'h0, 4'hF, 8'h06);
        expect_rsp("miss", 3'h1, 32'h0, 1'b1);
        send(3'h5, 32'h8, 32'h0, 4'hF, 8'h07);
        expect_rsp("badop", 3'h0, 32'h0, 1'b1);
        send(3'h0, 32'h8, 32'h12345678, 4'h3, 8'h08);
        expect_rsp("badmask", 3'h0, 32'h0, 1'b1);
        send(3'h4, 32'h8, 32'h0, 4'hF, 8'h09);
        expect_rsp("unchanged", 3'h1, 32'hDEAD55EF, 1'b0);

        send(3'h0, 32'h4, 32'h11223344, 4'hF, 8'h0A);
        send(3'h4, 32'h4, 32'h0, 4'hF, 8'h0B);
        expect_rsp("raw", 3'h1, 32'h11223344, 1'b0);

        h2d.d_ready = 1'b0;
        send(3'h4, 32'h0, 32'h0, 4'hF, 8'd1);
        send(3'h4, 32'h0, 32'h0, 4'hF, 8'd2);
        drive(3'h4, 32'h0, 32'h0, 4'hF, 2'd2, 8'd3);
        chk("bp_full", d2h.a_ready, 1'b0);
        chk("bp_head1", d2h.d_source, 8'd1);
        repeat (2) @(negedge clk);
        chk("bp_still_full", d2h.a_ready, 1'b0);
        chk("bp_head_stable", d2h.d_source, 8'd1);
        h2d.d_ready = 1'b1;
        @(negedge clk);
        chk("bp_head2", d2h.d_source, 8'd2);
        chk("bp_ready_back", d2h.a_ready, 1'b1);
        @(negedge clk);
        h2d.a_valid = 1'b0;
        chk("bp_head3", d2h.d_source, 8'd3);
        @(negedge clk);
        chk("bp_empty", d2h.d_valid, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            if (!h2d.a_valid || m_acc) begin
                r = $urandom_range(0, 9);
                h2d.a_valid   = ($urandom_range(0, 3) != 0);
                h2d.a_opcode  = (r < 4) ? Get : (r < 7) ? PutFullData :
                                (r < 9) ? PutPartialData : tl_a_op_e'(3'($urandom_range(0, 7)));
                h2d.a_address = ($urandom_range(0, 9) == 0) ? $urandom() :
                                BASE + 32'($urandom_range(0, MW - 1) * 4);
                h2d.a_size    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
                h2d.a_mask    = (h2d.a_opcode == PutFullData && $urandom_range(0, 7) != 0) ?
                                4'hF : 4'($urandom_range(0, 15));
                h2d.a_data    = $urandom();
                h2d.a_source  = 8'($urandom_range(0, 255));
            end
            h2d.d_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        h2d.a_valid = 1'b0;
        h2d.d_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("drain", d2h.d_valid, 1'b0);

        send(3'h0, 32'h8, 32'hCAFEF00D, 4'hF, 8'h10);
        expect_rsp("pre_rst_put", 3'h0, 32'h0, 1'b0);
        h2d.d_ready = 1'b0;
        send(3'h4, 32'h8, 32'h0, 4'hF, 8'h11);
        send(3'h4, 32'hC, 32'h0, 4'hF, 8'h12);
        chk("pre_rst_pending", d2h.d_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_d_valid", d2h.d_valid, 1'b0);
        chk("rst_async_a_ready", d2h.a_ready, 1'b0);
        chk("rst_async_init_done", init_done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n       = 1'b1;
        h2d.d_ready = 1'b1;
        wait_init("reinit_len");
        send(3'h4, 32'h8, 32'h0, 4'hF, 8'h13);
        expect_rsp("cleared", 3'h1, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL global_timeout: got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
